// File: rtl/aui_tx_pkg.sv
// Shared constants, FSM state type and width helper for the AUI TX sequencer.
package aui_tx_pkg;

  localparam int BITS_BLOCK        = 257;
  localparam int AM_MAPPED_WIDTH   = 10280;
  localparam int BLOCKS_PER_CW_DEF = AM_MAPPED_WIDTH / BITS_BLOCK;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AM   = 2'd1,
    DATA = 2'd2
  } seq_state_t;

  // Counter width that stays at least 1 bit for a modulus of 1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/aui_mod_counter.sv
// Modulo-MAX counter with synchronous clear; tc flags the terminal count MAX-1.
module aui_mod_counter
  import aui_tx_pkg::*;
#(
  parameter int MAX   = 40,
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  assign tc    = (count_q == WIDTH'(MAX - 1));
  assign count = count_q;

  // next count: clear wins over increment, increment wraps at tc
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = {WIDTH{1'b0}};
    end else if (inc) begin
      count_d = tc ? {WIDTH{1'b0}} : count_q + WIDTH'(1);
    end else begin
      count_d = count_q;
    end
  end

  // count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= {WIDTH{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/aui_tx_sequencer.sv
// Block-slot pacing for the AUI TX chain: AM slots at the head of every AM_PERIOD_CW-th word.
// Optional statistics ports are enabled by defining AUI_TX_SEQ_STATS_EN.
module aui_tx_sequencer
  import aui_tx_pkg::*;
#(
  parameter int BLOCKS_PER_CW = BLOCKS_PER_CW_DEF,
  parameter int AM_PERIOD_CW  = 4,
  parameter int AM_SLOTS      = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_enable,
  input  logic                          i_in_valid,
  output logic                          o_in_ready,
  output logic                          o_blk_valid,
  output logic                          o_am_slot,
  output logic [$clog2(AM_SLOTS):0]     o_am_index,
  output logic                          o_word_done,
  output logic                          o_am_word,
  output logic                          o_busy
`ifdef AUI_TX_SEQ_STATS_EN
  ,
  output logic [31:0]                   o_bubble_cnt,
  output logic [31:0]                   o_am_cnt
`endif
);

  localparam int BW = cnt_width(BLOCKS_PER_CW);
  localparam int CW = cnt_width(AM_PERIOD_CW);
  localparam int IW = $clog2(AM_SLOTS) + 1;

  seq_state_t    state_q, state_d;
  logic [BW-1:0] blk_cnt;
  logic [CW-1:0] cw_cnt;
  logic          blk_tc, cw_tc;
  logic          blk_inc, blk_clr, cw_inc, cw_clr;
  logic          accept;
  logic          blk_valid_q, blk_valid_d;
  logic          am_slot_q, am_slot_d;
  logic [IW-1:0] am_index_q, am_index_d;
  logic          word_done_q, word_done_d;

  aui_mod_counter #(.MAX(BLOCKS_PER_CW), .WIDTH(BW)) u_blk_cnt (
    .clk(clk), .rst(rst), .inc(blk_inc), .clr(blk_clr), .count(blk_cnt), .tc(blk_tc)
  );

  aui_mod_counter #(.MAX(AM_PERIOD_CW), .WIDTH(CW)) u_cw_cnt (
    .clk(clk), .rst(rst), .inc(cw_inc), .clr(cw_clr), .count(cw_cnt), .tc(cw_tc)
  );

  assign accept = i_in_valid & (state_q == DATA);

  // next-state and slot decode; enable is only honoured in IDLE and at a word boundary
  always_comb begin
    state_d     = state_q;
    blk_inc     = 1'b0;
    blk_clr     = 1'b0;
    cw_inc      = 1'b0;
    cw_clr      = 1'b0;
    blk_valid_d = 1'b0;
    am_slot_d   = 1'b0;
    am_index_d  = {IW{1'b0}};
    word_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        blk_clr = 1'b1;
        cw_clr  = 1'b1;
        if (i_enable) begin
          state_d = AM;
        end else begin
          state_d = IDLE;
        end
      end
      AM: begin
        blk_valid_d = 1'b1;
        am_slot_d   = 1'b1;
        am_index_d  = IW'(blk_cnt);
        blk_inc     = 1'b1;
        if (blk_cnt == BW'(AM_SLOTS - 1)) begin
          state_d = DATA;
        end else begin
          state_d = AM;
        end
      end
      DATA: begin
        if (accept) begin
          blk_valid_d = 1'b1;
          blk_inc     = 1'b1;
          if (blk_tc) begin
            word_done_d = 1'b1;
            cw_inc      = 1'b1;
            if (!i_enable) begin
              state_d = IDLE;
            end else if (cw_tc) begin
              state_d = AM;
            end else begin
              state_d = DATA;
            end
          end else begin
            state_d = DATA;
          end
        end else begin
          state_d = DATA;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // state and registered slot outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      blk_valid_q <= 1'b0;
      am_slot_q   <= 1'b0;
      am_index_q  <= {IW{1'b0}};
      word_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      blk_valid_q <= blk_valid_d;
      am_slot_q   <= am_slot_d;
      am_index_q  <= am_index_d;
      word_done_q <= word_done_d;
    end
  end

  assign o_blk_valid = blk_valid_q;
  assign o_am_slot   = am_slot_q;
  assign o_am_index  = am_index_q;
  assign o_word_done = word_done_q;
  assign o_in_ready  = (state_q == DATA);
  assign o_busy      = (state_q != IDLE);
  assign o_am_word   = (state_q != IDLE) && (cw_cnt == {CW{1'b0}});

`ifdef AUI_TX_SEQ_STATS_EN
  logic [31:0] bubble_cnt_q, am_cnt_q;

  // bubble counter saturates; AM-word counter ticks on the first AM slot of each word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt_q <= 32'd0;
      am_cnt_q     <= 32'd0;
    end else begin
      if ((state_q == DATA) && !accept && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
        bubble_cnt_q <= bubble_cnt_q + 32'd1;
      end
      if ((state_q == AM) && (blk_cnt == {BW{1'b0}})) begin
        am_cnt_q <= am_cnt_q + 32'd1;
      end
    end
  end

  assign o_bubble_cnt = bubble_cnt_q;
  assign o_am_cnt     = am_cnt_q;
`endif

endmodule

// File: tb/tb_aui_tx_sequencer.sv
// Scoreboard bench: default instance plus an AM_PERIOD_CW=1 / AM_SLOTS=1 instance on shared stimulus.
module tb_aui_tx_sequencer;

  localparam int B = 40;

  typedef struct packed {
    logic       am;
    logic [3:0] idx;
    logic       done;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  logic iv  = 1'b0;

  logic       rdy0, bv0, as0, wd0, amw0, bsy0;
  logic [1:0] idx0;
  logic       rdy1, bv1, as1, wd1, amw1, bsy1;
  logic [0:0] idx1;
`ifdef AUI_TX_SEQ_STATS_EN
  logic [31:0] bub0, amc0, bub1, amc1;
`endif

  always #5 clk = ~clk;

  aui_tx_sequencer dut0 (
    .clk(clk), .rst(rst), .i_enable(en), .i_in_valid(iv), .o_in_ready(rdy0),
    .o_blk_valid(bv0), .o_am_slot(as0), .o_am_index(idx0), .o_word_done(wd0),
    .o_am_word(amw0), .o_busy(bsy0)
`ifdef AUI_TX_SEQ_STATS_EN
    , .o_bubble_cnt(bub0), .o_am_cnt(amc0)
`endif
  );

  aui_tx_sequencer #(.AM_PERIOD_CW(1), .AM_SLOTS(1)) dut1 (
    .clk(clk), .rst(rst), .i_enable(en), .i_in_valid(iv), .o_in_ready(rdy1),
    .o_blk_valid(bv1), .o_am_slot(as1), .o_am_index(idx1), .o_word_done(wd1),
    .o_am_word(amw1), .o_busy(bsy1)
`ifdef AUI_TX_SEQ_STATS_EN
    , .o_bubble_cnt(bub1), .o_am_cnt(amc1)
`endif
  );

  // Reference model: slot position within the word and words since (re)start
  int   pp [2] = '{4, 1};
  int   ss [2] = '{2, 1};
  bit   m_run [2] = '{1'b0, 1'b0};
  int   m_pos [2] = '{0, 0};
  int   m_word[2] = '{0, 0};
  int   m_bub = 0;
  int   m_amc = 0;
  exp_t q0[$];
  exp_t q1[$];

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s inst%0d t=%0t actual=%0h expected=%0h", nm, k, $time, act, exp);
  endtask

  function automatic bit am_word_pred(input int k);
    return m_run[k] && ((m_word[k] % pp[k]) == 0);
  endfunction

  function automatic bit ready_pred(input int k);
    return m_run[k] && !(((m_word[k] % pp[k]) == 0) && (m_pos[k] < ss[k]));
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_run[k] = 1'b0; m_pos[k] = 0; m_word[k] = 0;
    end
    m_bub = 0; m_amc = 0;
    q0.delete(); q1.delete();
  endtask

  task automatic model_step(input int k);
    bit   is_am;
    exp_t e;
    if (rst) return;
    if (!m_run[k]) begin
      if (en) begin
        m_run[k] = 1'b1; m_pos[k] = 0; m_word[k] = 0;
      end
      return;
    end
    is_am = ((m_word[k] % pp[k]) == 0) && (m_pos[k] < ss[k]);
    if (!is_am && !iv && k == 0) m_bub++;
    if (is_am || iv) begin
      e.am   = is_am;
      e.idx  = is_am ? 4'(m_pos[k]) : 4'd0;
      e.done = (m_pos[k] == B - 1);
      if (is_am && m_pos[k] == 0 && k == 0) m_amc++;
      if (k == 0) q0.push_back(e); else q1.push_back(e);
      m_pos[k]++;
      if (m_pos[k] == B) begin
        m_pos[k] = 0;
        m_word[k]++;
        if (!en) m_run[k] = 1'b0;
      end
    end
  endtask

  task automatic cycle(input logic e_in, input logic v_in);
    en = e_in;
    iv = v_in;
    @(posedge clk);
    model_step(0);
    model_step(1);
    @(negedge clk);
    #2;
  endtask

  task automatic check_zero();
    chk("rst_blk_valid", 0, 32'(bv0), 32'd0);
    chk("rst_am_slot",   0, 32'(as0), 32'd0);
    chk("rst_am_index",  0, 32'(idx0), 32'd0);
    chk("rst_word_done", 0, 32'(wd0), 32'd0);
    chk("rst_in_ready",  0, 32'(rdy0), 32'd0);
    chk("rst_am_word",   0, 32'(amw0), 32'd0);
    chk("rst_busy",      0, 32'(bsy0), 32'd0);
    chk("rst_blk_valid", 1, 32'(bv1), 32'd0);
    chk("rst_busy",      1, 32'(bsy1), 32'd0);
    chk("rst_am_word",   1, 32'(amw1), 32'd0);
  endtask

  task automatic mon_inst(input int k, input logic bv, input logic as_, input logic [3:0] idx,
                          input logic wd, input logic rdy, input logic bsy, input logic amw);
    int   qs;
    exp_t e;
    qs = (k == 0) ? q0.size() : q1.size();
    if (bv) begin
      chk("slot_expected", k, 32'(qs != 0), 32'd1);
      if (qs != 0) begin
        e = (k == 0) ? q0.pop_front() : q1.pop_front();
        chk("am_slot",   k, 32'(as_), 32'(e.am));
        chk("am_index",  k, 32'(idx), 32'(e.idx));
        chk("word_done", k, 32'(wd),  32'(e.done));
      end
    end else begin
      chk("slot_missing", k, 32'(qs), 32'd0);
      chk("word_done_idle", k, 32'(wd), 32'd0);
      if (k == 0) q0.delete(); else q1.delete();
    end
    chk("in_ready", k, 32'(rdy), 32'(ready_pred(k)));
    chk("busy",     k, 32'(bsy), 32'(m_run[k]));
    chk("am_word",  k, 32'(amw), 32'(am_word_pred(k)));
  endtask

  // Monitor: compares DUT outputs against the model on every falling edge
  initial begin
    @(negedge clk);
    forever begin
      @(negedge clk);
      mon_inst(0, bv0, as0, 4'(idx0), wd0, rdy0, bsy0, amw0);
      mon_inst(1, bv1, as1, 4'(idx1), wd1, rdy1, bsy1, amw1);
`ifdef AUI_TX_SEQ_STATS_EN
      chk("bubble_cnt", 0, bub0, 32'(m_bub));
      chk("am_cnt",     0, amc0, 32'(m_amc));
`endif
    end
  end

  // Stimulus
  initial begin
    logic e_r;
    repeat (3) @(negedge clk);
    #2;
    check_zero();
    rst = 1'b0;
    model_reset();

    repeat (170) cycle(1'b1, 1'b1);
    repeat (5)   cycle(1'b1, 1'b0);
    repeat (60)  cycle(1'b1, 1'b1);
    repeat (3)   cycle(1'b0, 1'b1);
    repeat (10)  cycle(1'b1, 1'b1);
    repeat (45)  cycle(1'b0, 1'b1);
    repeat (5)   cycle(1'b0, 1'b0);
    for (int i = 0; i < 100; i++) cycle(1'b1, 1'($urandom_range(0, 3) != 0));
    repeat (20)  cycle(1'b1, 1'b1);

    rst = 1'b1;
    model_reset();
    #1;
    check_zero();
    #1;
    repeat (2) cycle(1'b1, 1'b1);
    rst = 1'b0;
    repeat (60) cycle(1'b1, 1'b1);

    e_r = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 49) == 0) e_r = ~e_r;
      cycle(e_r, 1'($urandom_range(0, 3) != 0));
    end
    repeat (120) cycle(1'b0, 1'b1);
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/aui_tx_sequencer.md
Name: aui_tx_sequencer

Overview:
- Pacing controller for the 1.6T AUI TX chain: flow distributor -> x85 scramblers -> am_insertion -> rs_module -> lanes.
- Counts 257-bit block slots per flow into 10280-bit AM-mapped words (40 blocks per flow).
- Every AM_PERIOD_CW words, stalls the upstream and reserves AM_SLOTS block slots for alignment-marker insertion.
- Emits the block strobe, AM-slot flags and word-complete pulse that replace the free-running valids currently daisy-chained between blocks.

Parameters:
- BLOCKS_PER_CW, 40, block slots per flow per AM-mapped word (10280/257).
- AM_PERIOD_CW, 4, words per AM period; word 0 of each period carries the AM.
- AM_SLOTS, 2, leading block slots of word 0 replaced by AM; legal range 1..BLOCKS_PER_CW-1.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- i_enable  in  1  run request
- i_in_valid  in  1  upstream block pair available
- o_in_ready  out  1  sequencer accepts a block pair this cycle
- o_blk_valid  out  1  one block slot (data or AM) is issued to scramblers/am_insertion
- o_am_slot  out  1  current slot is an AM slot; the scrambler holds its state
- o_am_index  out  $clog2(AM_SLOTS)+1  AM slot index, 0..AM_SLOTS-1
- o_word_done  out  1  1-cycle pulse with the last slot of a word; drives am_insertion i_valid
- o_am_word  out  1  current word carries an AM; stable for the whole word
- o_busy  out  1  state != IDLE

Behaviour:
- Reset values: all outputs 0, state IDLE, blk_cnt 0, cw_cnt 0.
- Registered outputs: o_blk_valid, o_am_slot, o_am_index, o_word_done.
- Moore decodes of registered state: o_in_ready, o_am_word, o_busy.
- FSM states:
  - IDLE: o_in_ready = 0.
    - i_enable = 1 -> AM, with cw_cnt = 0 and blk_cnt = 0.
  - AM: o_in_ready = 0.
    - Each cycle issues one slot, 1 cycle after entry: o_blk_valid = 1, o_am_slot = 1, o_am_index = blk_cnt.
    - blk_cnt++.
    - At blk_cnt == AM_SLOTS-1 -> DATA.
  - DATA: o_in_ready = 1.
    - Accept = i_in_valid & o_in_ready.
    - On accept: next cycle o_blk_valid = 1, o_am_slot = 0; blk_cnt++.
    - No accept (bubble): counters hold and o_blk_valid = 0.
    - Last slot (blk_cnt == BLOCKS_PER_CW-1) accepted: o_word_done pulses with that slot's o_blk_valid, blk_cnt -> 0, cw_cnt wraps mod AM_PERIOD_CW.
    - Next state: cw_cnt wraps to 0 -> AM; stay DATA otherwise; i_enable low -> IDLE (takes priority).
- Latency: accept -> o_blk_valid is 1 cycle. Slot rate is at most one per cycle.
- o_am_word = 1 while cw_cnt == 0 and state != IDLE.
- Boundary conditions:
  - Word boundary: o_word_done is never asserted for a partial word.
  - AM period with AM_PERIOD_CW = 1: every word starts in AM.
  - i_enable low mid-word: the current word completes, including AM slots and waiting through bubbles, then IDLE. Restart always begins with AM (cw_cnt = 0).
  - i_enable toggled within one word: no effect if high again at the boundary.
  - rst asserted mid-operation: immediate return to reset values; a partial word is discarded.
  - i_in_valid high during AM or IDLE: ignored, no accept.

Optional Feature:
- Macro: AUI_TX_SEQ_STATS_EN.
- Defined: adds o_bubble_cnt (32-bit saturating; DATA cycles with no accept) and o_am_cnt (32-bit wrapping; AM words started). Both clear on rst.
- Undefined: these ports and counters do not exist; the remaining behaviour is identical.

Decomposition:
- Package aui_tx_pkg holds:
  - constants BITS_BLOCK = 257, AM_MAPPED_WIDTH = 10280, BLOCKS_PER_CW_DEF = AM_MAPPED_WIDTH/BITS_BLOCK;
  - typedef enum logic [1:0] seq_state_t {IDLE, AM, DATA}.
- Sub-module aui_mod_counter (params MAX, WIDTH; ports clk, rst, inc, clr, count, tc) is instantiated twice: blk_cnt and cw_cnt.

Test Plan:
- Reset then i_enable = 1, i_in_valid = 1 constant -> 2 AM slots (o_am_index 0, 1), then 38 data slots. o_word_done on slot 40 (cycle 41 after enable). Words 1-3 have 40 data slots and o_am_word = 0. Word 4 starts in AM again.
- i_in_valid low for 5 cycles mid-word -> no o_blk_valid for those cycles, blk_cnt held, word still exactly 40 slots. With the stats macro defined, bubble count = 5.
- i_enable dropped at slot 10 of word 2 -> word 2 completes (o_word_done asserted) -> IDLE, o_in_ready = 0. Re-enable -> AM slots first.
- rst pulsed at slot 20 -> all outputs 0 the same cycle. After release with i_enable high, sequence restarts with AM slot 0.
- i_in_valid = 1 throughout an AM phase -> o_in_ready = 0 and no data accepted for exactly 2 cycles per AM period.
- Parameter override AM_PERIOD_CW = 1, AM_SLOTS = 1 -> every word is 1 AM slot + 39 data slots, and o_am_word stays 1.
